// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, ROB entry and CDB broadcast formats.
// The ROB sizing lives here so that RS, LSQ and regfile tag widths share one definition.
package rv32i_types;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    rv32i_opcode          opcode;
    logic [4:0]           rds;
    logic [31:0]          rob_val;
    logic                 commit;
    logic                 br_en;
    logic [31:0]          br_target;
  } rob_t;

  typedef struct packed {
    logic                 br_en;
    logic [31:0]          br_target;
    logic [31:0]          value;
    logic [ROB_TAG_W-1:0] tag;
    logic                 valid;
  } cdb_t;

  // Only these two opcodes retire without writing a destination register.
  function automatic logic writes_rd(rv32i_opcode op, logic [4:0] rd);
    return (op != op_br) && (op != op_store) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand lookup and commit signals between the pipeline and the ROB.
interface reorder_buffer_if
  import rv32i_types::*;
();

  logic                 disp_valid;
  rv32i_opcode          disp_opcode;
  logic [4:0]           disp_rd;
  logic                 disp_ready;
  logic [ROB_TAG_W-1:0] disp_tag;

  cdb_t                 cdb;

  logic [ROB_TAG_W-1:0] rd_tag1;
  logic [ROB_TAG_W-1:0] rd_tag2;
  logic                 rd_ready1;
  logic                 rd_ready2;
  logic [31:0]          rd_value1;
  logic [31:0]          rd_value2;

  logic                 commit_valid;
  rob_t                 commit_entry;
  logic                 commit_regwr;
  logic                 flush;

  modport master (
    output disp_valid, disp_opcode, disp_rd, cdb, rd_tag1, rd_tag2,
    input  disp_ready, disp_tag, rd_ready1, rd_ready2, rd_value1, rd_value2,
    input  commit_valid, commit_entry, commit_regwr, flush
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_rd, cdb, rd_tag1, rd_tag2,
    output disp_ready, disp_tag, rd_ready1, rd_ready2, rd_value1, rd_value2,
    output commit_valid, commit_entry, commit_regwr, flush
  );

endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate, out-of-order CDB writeback,
// in-order single-instruction commit with branch flush.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob_if
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  rob_t             r_entry [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  rob_t             w_head_entry;
  logic             w_full;
  logic             w_commit;
  logic             w_flush;
  logic             w_alloc;
  logic             w_wb;
  logic             w_hit1;
  logic             w_hit2;

  // NOTE: every signal gets a value before any condition, so no path leaves one unassigned (no latch).
  always_comb begin
    w_head_entry = r_entry[r_head];
    w_full       = (r_count == FULL_COUNT);
    w_commit     = (r_count != '0) && w_head_entry.commit;
    w_flush      = w_commit && w_head_entry.br_en;
    // A full ROB refuses dispatch even if head retires this cycle.
    w_alloc      = rob_if.disp_valid && !w_full && !w_flush;
    w_wb         = rob_if.cdb.valid && r_valid[rob_if.cdb.tag];

    w_hit1 = r_valid[rob_if.rd_tag1] && rob_if.cdb.valid && (rob_if.cdb.tag == rob_if.rd_tag1);
    w_hit2 = r_valid[rob_if.rd_tag2] && rob_if.cdb.valid && (rob_if.cdb.tag == rob_if.rd_tag2);

    rob_if.disp_ready   = !w_full;
    rob_if.disp_tag     = r_tail;
    rob_if.commit_valid = w_commit;
    rob_if.commit_entry = w_head_entry;
    rob_if.commit_regwr = w_commit && writes_rd(w_head_entry.opcode, w_head_entry.rds);
    rob_if.flush        = w_flush;

    rob_if.rd_ready1 = r_valid[rob_if.rd_tag1] && (r_entry[rob_if.rd_tag1].commit || w_hit1);
    rob_if.rd_ready2 = r_valid[rob_if.rd_tag2] && (r_entry[rob_if.rd_tag2].commit || w_hit2);
    rob_if.rd_value1 = w_hit1 ? rob_if.cdb.value : r_entry[rob_if.rd_tag1].rob_val;
    rob_if.rd_value2 = w_hit2 ? rob_if.cdb.value : r_entry[rob_if.rd_tag2].rob_val;
  end

  // NOTE: state updates use <= so every branch below sees the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      // NOTE: the entry array is reset because commit_entry exposes entry[head] and must read 0.
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_entry[i].commit <= 1'b0;
    end else begin
      if (w_wb) begin
        r_entry[rob_if.cdb.tag].rob_val   <= rob_if.cdb.value;
        r_entry[rob_if.cdb.tag].br_en     <= rob_if.cdb.br_en;
        r_entry[rob_if.cdb.tag].br_target <= rob_if.cdb.br_target;
        r_entry[rob_if.cdb.tag].commit    <= 1'b1;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_entry[r_tail] <= '{tag: r_tail, opcode: rob_if.disp_opcode, rds: rob_if.disp_rd,
                             rob_val: 32'd0, commit: 1'b0, br_en: 1'b0, br_target: 32'd0};
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
